// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: state encoding,
// owner encoding, timeout defaults and the round-robin pick helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    BUSY_CPU = 2'b01,
    BUSY_DMA = 2'b10
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT = 15;
  // Timer width covers the full 1..255 TIMEOUT range.
  localparam int unsigned TIMER_W = 8;

  // Round-robin choice between the two requesters. On a tie the one not
  // granted last wins; a lone requester always wins. With no requester the
  // result is don't-care.
  function automatic logic pick_owner(input logic cpu_v, input logic dma_v,
                                      input logic last_grant);
    logic owner;
    if (cpu_v && dma_v) begin
      owner = ~last_grant;
    end else if (dma_v) begin
      owner = OWN_DMA;
    end else begin
      owner = OWN_CPU;
    end
    return owner;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the arbiter: CPU port, DMA port, memory port and the
// abort status. The arbiter uses the slave view, its environment the master.
interface mem_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 8
);
  // CPU controller side
  logic             cpu_rd;
  logic             cpu_wr;
  logic [AW-1:0]    cpu_adr;
  logic [WIDTH-1:0] cpu_wd;
  logic [WIDTH-1:0] cpu_rdata;
  logic             cpu_done;
  logic             cpu_stall;
  // DMA / debug side
  logic             dma_req;
  logic             dma_we;
  logic [AW-1:0]    dma_adr;
  logic [WIDTH-1:0] dma_wd;
  logic [WIDTH-1:0] dma_rdata;
  logic             dma_done;
  // Memory side
  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_adr;
  logic [WIDTH-1:0] mem_wd;
  logic [WIDTH-1:0] mem_rd;
  logic             mem_ack;
  // Abort status
  logic             err;
  logic             err_src;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_adr, cpu_wd,
    input  dma_req, dma_we, dma_adr, dma_wd,
    input  mem_rd, mem_ack,
    output cpu_rdata, cpu_done, cpu_stall,
    output dma_rdata, dma_done,
    output mem_req, mem_we, mem_adr, mem_wd,
    output err, err_src
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_adr, cpu_wd,
    output dma_req, dma_we, dma_adr, dma_wd,
    output mem_rd, mem_ack,
    input  cpu_rdata, cpu_done, cpu_stall,
    input  dma_rdata, dma_done,
    input  mem_req, mem_we, mem_adr, mem_wd,
    input  err, err_src
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Busy-cycle counter for the arbiter. clr zeroes it, en counts one busy
// cycle without acknowledge. expired flags the cycle whose count step
// reaches TIMEOUT, so the abort lands exactly TIMEOUT busy cycles after grant.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST_CNT = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  // Next count: clear wins, otherwise step on enable, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {TIMER_W{1'b0}};
    end else if (en) begin
      cnt_d = cnt_q + TIMER_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {TIMER_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en & (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the unified memory between the CPU controller and a
// DMA/debug requester. One access at a time, round-robin on ties, request
// held until acknowledge or aborted after TIMEOUT unacknowledged cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int          AW      = 8,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_adr_q, mem_adr_d;
  logic [WIDTH-1:0] mem_wd_q, mem_wd_d;
  logic [WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [WIDTH-1:0] dma_rdata_q, dma_rdata_d;
  logic             cpu_done_q, cpu_done_d;
  logic             dma_done_q, dma_done_d;
  logic             err_q, err_d;
  logic             err_src_q, err_src_d;

  logic cpu_v_s;
  logic dma_v_s;
  logic grant_s;
  logic grant_dma_s;
  logic busy_s;
  logic timer_clr_s;
  logic timer_en_s;
  logic expired_s;

  // A requester whose done pulse is out this cycle is still showing the
  // request it just finished; masking it prevents a second grant.
  assign cpu_v_s     = (bus.cpu_rd | bus.cpu_wr) & ~cpu_done_q;
  assign dma_v_s     = bus.dma_req & ~dma_done_q;
  assign grant_s     = cpu_v_s | dma_v_s;
  assign grant_dma_s = pick_owner(cpu_v_s, dma_v_s, last_grant_q);

  assign busy_s      = (state_q == BUSY_CPU) | (state_q == BUSY_DMA);
  assign timer_clr_s = (state_q == IDLE);
  assign timer_en_s  = busy_s & ~bus.mem_ack;

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr_s),
    .en      (timer_en_s),
    .expired (expired_s)
  );

  // State register plus round-robin history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= OWN_DMA;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next state: grant from IDLE, leave BUSY on acknowledge or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          state_d = grant_dma_s ? BUSY_DMA : BUSY_CPU;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_CPU, BUSY_DMA: begin
        if (bus.mem_ack || expired_s) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: load the memory port on grant, capture
  // read data on acknowledge, pulse done (and err on abort) when leaving BUSY.
  // Acknowledge takes priority over a coincident timeout because the timer
  // only counts cycles without acknowledge.
  always_comb begin
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_adr_d    = mem_adr_q;
    mem_wd_d     = mem_wd_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cpu_done_d   = 1'b0;
    dma_done_d   = 1'b0;
    err_d        = 1'b0;
    err_src_d    = err_src_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          mem_req_d    = 1'b1;
          last_grant_d = grant_dma_s;
          if (grant_dma_s == OWN_DMA) begin
            mem_we_d  = bus.dma_we;
            mem_adr_d = bus.dma_adr;
            mem_wd_d  = bus.dma_wd;
          end else begin
            // Read and write together is treated as a write.
            mem_we_d  = bus.cpu_wr;
            mem_adr_d = bus.cpu_adr;
            mem_wd_d  = bus.cpu_wd;
          end
        end else begin
          mem_req_d = 1'b0;
        end
      end
      BUSY_CPU: begin
        if (bus.mem_ack) begin
          mem_req_d  = 1'b0;
          cpu_done_d = 1'b1;
          if (!mem_we_q) begin
            cpu_rdata_d = bus.mem_rd;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
        end else if (expired_s) begin
          mem_req_d  = 1'b0;
          cpu_done_d = 1'b1;
          err_d      = 1'b1;
          err_src_d  = OWN_CPU;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      BUSY_DMA: begin
        if (bus.mem_ack) begin
          mem_req_d  = 1'b0;
          dma_done_d = 1'b1;
          if (!mem_we_q) begin
            dma_rdata_d = bus.mem_rd;
          end else begin
            dma_rdata_d = dma_rdata_q;
          end
        end else if (expired_s) begin
          mem_req_d  = 1'b0;
          dma_done_d = 1'b1;
          err_d      = 1'b1;
          err_src_d  = OWN_DMA;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Registered outputs; reset discards any in-flight access silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= {AW{1'b0}};
      mem_wd_q    <= {WIDTH{1'b0}};
      cpu_rdata_q <= {WIDTH{1'b0}};
      dma_rdata_q <= {WIDTH{1'b0}};
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
      err_q       <= 1'b0;
      err_src_q   <= 1'b0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_adr_q   <= mem_adr_d;
      mem_wd_q    <= mem_wd_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_done_q  <= cpu_done_d;
      dma_done_q  <= dma_done_d;
      err_q       <= err_d;
      err_src_q   <= err_src_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_adr   = mem_adr_q;
  assign bus.mem_wd    = mem_wd_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.dma_done  = dma_done_q;
  assign bus.err       = err_q;
  assign bus.err_src   = err_src_q;

  // Stall follows the CPU request until its done pulse; forced low in reset
  // so that every output reads 0 while reset is held.
  assign bus.cpu_stall = reset & (bus.cpu_rd | bus.cpu_wr) & ~cpu_done_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified memory of the multicycle CPU between the CPU controller's memory accesses (instruction fetch and load/store) and a secondary DMA/debug requester.
- Grants one requester at a time with round-robin tie-breaking.
- Holds the memory request until the memory acknowledges, or aborts it on timeout.
- Stalls the CPU controller's state advance while the CPU's access is pending.
- Sits between the controller/datapath memory signals and the memory model.

## Interface
Parameters:
- WIDTH, 8, data width.
- AW, 8, address width.
- TIMEOUT, 15, busy cycles without mem_ack before abort (1..255).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  CPU read request (from the controller's memread).
- cpu_wr  in  1  CPU write request (from the controller's memwrite).
- cpu_adr  in  AW  CPU address.
- cpu_wd  in  WIDTH  CPU write data.
- cpu_rdata  out  WIDTH  registered CPU read data.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_stall  out  1  CPU access pending; the controller holds its state.
- dma_req  in  1  DMA request.
- dma_we  in  1  DMA write enable.
- dma_adr  in  AW  DMA address.
- dma_wd  in  WIDTH  DMA write data.
- dma_rdata  out  WIDTH  registered DMA read data.
- dma_done  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_adr  out  AW  memory address.
- mem_wd  out  WIDTH  memory write data.
- mem_rd  in  WIDTH  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion.
- err  out  1  timeout abort pulse, coincident with done.
- err_src  out  1  owner of the last abort: 0=CPU, 1=DMA.

## Operation
- States: IDLE, BUSY_CPU, BUSY_DMA.
- CPU request = cpu_rd|cpu_wr. If both are high, the access is a write.
- Requesters hold request, address and data stable until their done pulse.
- IDLE:
  - A requester whose done is high this cycle is masked, so there is no re-grant on a stale request.
  - Single requester: grant it.
  - Both requesting: grant the one not granted last. last_grant resets to DMA, so the CPU wins the first tie.
- On grant, register the owner's address/data/we into mem_adr/mem_wd/mem_we, set mem_req=1, update last_grant, clear the timeout counter, and enter BUSY_x.
- BUSY_x with mem_ack=1:
  - Read: capture mem_rd into x_rdata.
  - Drop mem_req, pulse x_done, return to IDLE.
- BUSY_x with mem_ack=0: the counter increments.
  - On the cycle the counter reaches TIMEOUT: drop mem_req, pulse x_done and err, set err_src, return to IDLE.
  - x_rdata is unchanged on abort.
  - If mem_ack and the timeout occur together, mem_ack wins and err=0.
- mem_ack in IDLE is ignored.
- cpu_stall = (cpu_rd|cpu_wr) & ~cpu_done (combinational).
- Reset values (asynchronous, reset low):
  - State IDLE; last_grant=DMA; counter 0.
  - All outputs 0, including the rdata registers and err_src.
  - An in-flight access is discarded with no done pulse.

## Timing
- Request high in IDLE at edge k → mem_req high after edge k.
- mem_ack sampled high at edge m → done (and rdata) valid after edge m; mem_req low after edge m.
- Minimum access: 2 cycles request-to-done with zero-wait memory (ack in the first busy cycle).
- Back-to-back: the other requester's grant is evaluated in the done cycle, so mem_req drops for exactly 1 cycle between accesses.
- Timeout abort: done/err follow TIMEOUT busy cycles after grant.
- mem_* outputs are registered and stable for the whole busy period.

## Structure
- Shared package/header mem_arb_pkg:
  - State encodings: IDLE=2'b00, BUSY_CPU=2'b01, BUSY_DMA=2'b10.
  - Owner constants: OWN_CPU=0, OWN_DMA=1.
  - Default TIMEOUT.
- Sub-module mem_arb_timer: counter with clear/enable inputs and an expired output, parameterised by TIMEOUT. Everything else lives in mem_arbiter.

## Test plan
- CPU-only read: cpu_rd=1, cpu_adr=8'h10; memory acks the 2nd busy cycle with 8'hA5 → mem_adr=8'h10, mem_we=0; cpu_done 1 cycle; cpu_rdata=8'hA5; cpu_stall high until done.
- Simultaneous requests twice: CPU and DMA both pending, zero-wait memory → grant order CPU, DMA, CPU, DMA; single idle gap between accesses; no double grant on a held request.
- DMA write: dma_we=1, dma_adr=8'h3C, dma_wd=8'h5A → mem_we=1, mem_wd=8'h5A held until ack; dma_done pulse; dma_rdata unchanged.
- Timeout: memory never acks, TIMEOUT=15 → after 15 busy cycles err=1 with cpu_done, err_src=0, mem_req low; ack arriving exactly on cycle 15 → err=0.
- Reset mid-access: assert reset during BUSY_DMA → all outputs 0 immediately; no done pulse; after release, a tie grants the CPU first.
- Illegal cpu_rd=cpu_wr=1 → performed as a write.
